aes_key_expand: RTL and testbench

//  Iterative AES-128 key schedule. Expands one 128-bit cipher key into 11 round keys
//  (rk0..rk10), one round key per clock, and holds them in an internal register file.

---
 rtl/aes_key_expand.sv | 168 ++++++++++++++++
 tb/tb_aes_key_expand.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expand
// Description : Iterative AES-128 key schedule, one round key per clock,
//               11 round keys held in a register file with a registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand #(
    parameter int KEY_W      = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    output logic             busy,
    output logic             done,
    output logic             key_valid,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key
);

    localparam logic [3:0] c_LAST = 4'(NUM_ROUNDS);

    // FIPS-197 S-box, byte 0x00 in the most significant position
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return c_SBOX[{~x, 3'b000} +: 8];
    endfunction

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_load;
    logic            w_step;
    logic            w_finish;

    logic [3:0]      r_round;
    logic [7:0]      r_rcon;
    logic [KEY_W-1:0] r_rk [0:NUM_ROUNDS];
    logic            r_busy;
    logic            r_done;
    logic            r_key_valid;
    logic [KEY_W-1:0] r_rd_key;

    logic [KEY_W-1:0] w_prev;
    logic [31:0]     w_w3;
    logic [31:0]     w_rot;
    logic [31:0]     w_sub;
    logic [31:0]     w_t;
    logic [31:0]     w_w0n;
    logic [31:0]     w_w1n;
    logic [31:0]     w_w2n;
    logic [31:0]     w_w3n;
    logic [KEY_W-1:0] w_next_rk;
    logic [7:0]      w_rcon_next;

    // Round function datapath: previous round key -> next round key
    assign w_prev = r_rk[r_round - 4'd1];
    assign w_w3   = w_prev[31:0];
    assign w_rot  = {w_w3[23:0], w_w3[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_sbox
        assign w_sub[8*j +: 8] = sbox(w_rot[8*j +: 8]);
    end

    assign w_t         = w_sub ^ {r_rcon, 24'h000000};
    assign w_w0n       = w_prev[127:96] ^ w_t;
    assign w_w1n       = w_prev[95:64]  ^ w_w0n;
    assign w_w2n       = w_prev[63:32]  ^ w_w1n;
    assign w_w3n       = w_prev[31:0]   ^ w_w2n;
    assign w_next_rk   = {w_w0n, w_w1n, w_w2n, w_w3n};
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = EXPAND;
                end
            end
            EXPAND: begin
                w_step = 1'b1;
                if (r_round == c_LAST) begin
                    w_finish     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_round     <= 4'd0;
            r_rcon      <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_key_valid <= 1'b0;
            r_rd_key    <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                r_rk[i] <= '0;
            end
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_rk[0]     <= key;
                r_round     <= 4'd1;
                r_rcon      <= 8'h01;
                r_key_valid <= 1'b0;
                r_busy      <= 1'b1;
            end
            if (w_step) begin
                r_rk[r_round] <= w_next_rk;
                r_rcon        <= w_rcon_next;
                r_round       <= r_round + 4'd1;
            end
            if (w_finish) begin
                r_busy      <= 1'b0;
                r_key_valid <= 1'b1;
            end
            // Read port runs every cycle; out-of-range indices read as zero
            r_rd_key <= (rd_idx > c_LAST) ? '0 : r_rk[rd_idx];
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign key_valid = r_key_valid;
    assign rd_key    = r_rd_key;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_expand
// Description : Self-checking bench for aes_key_expand against a word-level
//               FIPS-197 key schedule model with a derived S-box.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand;

    localparam logic [127:0] c_K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_K1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_Z_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] c_Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic         key_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    aes_key_expand #(.KEY_W(128), .NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid),
        .rd_idx    (rd_idx),
        .rd_key    (rd_key)
    );

    always #5 clk = ~clk;

    // S-box derived from GF(2^8) inversion and the affine transform
    logic [7:0] sbox_t [0:255];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        logic [7:0] r;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        s = inv;
        r = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        w[0] = k[127:96];
        w[1] = k[95:64];
        w[2] = k[63:32];
        w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]}
                    ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    // Transaction-level model: an accepted start schedules ten round-key writes
    logic [127:0] m_rk [0:10];
    logic [127:0] m_key  = '0;
    logic [127:0] m_rd   = '0;
    int           m_left = 0;
    int           m_step = 0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_valid = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= 10; i++) m_rk[i] <= '0;
            m_rd    <= '0;
            m_left  <= 0;
            m_step  <= 0;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            m_rd   <= (rd_idx <= 4'd10) ? m_rk[rd_idx] : '0;
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    m_key   <= key;
                    m_rk[0] <= key;
                    m_step  <= 1;
                    m_left  <= 10;
                    m_busy  <= 1'b1;
                    m_valid <= 1'b0;
                end
            end else begin
                m_rk[m_step] <= round_key(m_key, m_step);
                m_step       <= m_step + 1;
                m_left       <= m_left - 1;
                if (m_left == 1) begin
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                    m_valid <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", 128'(busy), 128'(m_busy));
            chk("cyc_done", 128'(done), 128'(m_done));
            chk("cyc_key_valid", 128'(key_valid), 128'(m_valid));
            chk("cyc_rd_key", rd_key, m_rd);
        end
    end

    task automatic read_chk(input logic [3:0] idx, input logic [127:0] exp, input string nm);
        @(negedge clk);
        rd_idx = idx;
        @(negedge clk);
        chk(nm, rd_key, exp);
    endtask

    // Drives start at the current negedge and waits (bounded) for done
    task automatic run(input logic [127:0] k, input bit rep);
        int cnt;
        start = 1'b1;
        key   = k;
        @(negedge clk);
        start = 1'b0;
        key   = ~k;
        chk("kv_drop", 128'(key_valid), 128'(1'b0));
        chk("busy_on", 128'(busy), 128'(1'b1));
        cnt = 0;
        while (!done && cnt < 30) begin
            @(negedge clk);
            cnt++;
            if (rep && (cnt == 3 || cnt == 7)) begin
                start = 1'b1;
                key   = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_latency", 128'(cnt), 128'(10));
    endtask

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        key    = '0;
        rd_idx = 4'd0;
        for (int x = 0; x < 256; x++) sbox_t[x] = sbox_calc(8'(x));

        chk("model_sbox_00", 128'(sbox_t[8'h00]), 128'(8'h63));
        chk("model_sbox_53", 128'(sbox_t[8'h53]), 128'(8'hed));
        chk("model_k1_rk10", round_key(c_K1, 10), c_K1_RK10);
        chk("model_z_rk1", round_key('0, 1), c_Z_RK1);

        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_rd_key", rd_key, '0);
        rst    = 1'b1;
        chk_en = 1'b1;

        // FIPS-197 key
        run(c_K1, 1'b0);
        read_chk(4'd1, c_K1_RK1, "t1_rk1");
        read_chk(4'd10, c_K1_RK10, "t1_rk10");

        // Zero key following a completed expansion
        run('0, 1'b0);
        read_chk(4'd1, c_Z_RK1, "t2_rk1");
        read_chk(4'd10, c_Z_RK10, "t2_rk10");

        // Start re-pulsed mid-expansion is ignored
        run(c_K1, 1'b1);
        read_chk(4'd1, c_K1_RK1, "t3_rk1");
        read_chk(4'd10, c_K1_RK10, "t3_rk10");

        // Start in the done cycle is accepted
        run('0, 1'b0);
        run(c_K1, 1'b0);
        read_chk(4'd10, c_K1_RK10, "b2b_rk10");

        // Asynchronous reset mid-expansion
        start = 1'b1;
        key   = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 128'(busy), 128'(1'b0));
        chk("arst_done", 128'(done), 128'(1'b0));
        chk("arst_key_valid", 128'(key_valid), 128'(1'b0));
        chk("arst_rd_key", rd_key, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run(c_K1, 1'b0);
        read_chk(4'd10, c_K1_RK10, "t4_rk10");

        // Read sweep, including out-of-range indices
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_idx = 4'(i);
        end
        @(negedge clk);
        read_chk(4'd0, c_K1, "t6_rk0");
        read_chk(4'd11, '0, "t6_idx11");
        read_chk(4'd15, '0, "t6_idx15");
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
